// File: rtl/jstk_spi_responder.sv
// jstk_spi_responder
//   SPI mode-0 responder emulating the PmodJSTK joystick. Every frame returns
//   {X[7:0], X[9:8], Y[7:0], Y[9:8], Buttons} and captures the first byte the
//   initiator sends as a command. A SetLED command (byte[7:2] == LED_CMD)
//   updates Led when the frame completes. SS/SCLK/MOSI are oversampled in the
//   Clk domain; nothing is clocked by SCLK.
//
//   Parameters: NUM_BYTES (bytes per frame), SYNC_STAGES (synchronizer depth,
//   >= 2), LED_CMD (SetLED opcode in command bits [7:2]).
//   Ports:
//     Clk, Reset        system clock, asynchronous active-high reset
//     X_pos, Y_pos      10-bit joystick position to report
//     Buttons           {btn2,btn1,btn0} to report
//     SS, SCLK, MOSI    SPI from the initiator (SS active low, SCLK idle low)
//     MISO              SPI data to the initiator
//     Led               last decoded {LD2,LD1}; Led_valid pulses on update
//     Frame_done        pulse after a full frame followed by SS rise
//     Frame_abort       pulse when SS rises before the frame completed
//     Busy              high whenever a frame is in progress
//   Optional build macro JSTK_MISO_TRISTATE_EN: MISO floats while idle.
module jstk_spi_responder #(
  parameter int unsigned NUM_BYTES   = 5,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [5:0]  LED_CMD     = 6'b100000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [9:0] X_pos,
  input  logic [9:0] Y_pos,
  input  logic [2:0] Buttons,
  input  logic       SS,
  input  logic       SCLK,
  input  logic       MOSI,
  output logic       MISO,
  output logic [1:0] Led,
  output logic       Led_valid,
  output logic       Frame_done,
  output logic       Frame_abort,
  output logic       Busy
);

  localparam int unsigned CNT_W   = $clog2(NUM_BYTES + 1);
  localparam int unsigned FRAME_W = NUM_BYTES * 8;
  localparam int unsigned IMG_W   = 40;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   ss_dly_q, ss_dly_d;
  logic                   sclk_dly_q, sclk_dly_d;
  logic [FRAME_W-1:0]     tx_q, tx_d;
  logic [7:0]             rx_q, rx_d;
  logic [7:0]             cmd_q, cmd_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]       byte_cnt_q, byte_cnt_d;
  logic                   miso_q, miso_d;
  logic [1:0]             led_q, led_d;
  logic                   led_valid_q, led_valid_d;
  logic                   done_q, done_d;
  logic                   abort_q, abort_d;

  logic                   ss_s, sclk_s, mosi_s;
  logic                   ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic [IMG_W-1:0]       img;
  logic [FRAME_W+IMG_W-1:0] img_wide;
  logic [FRAME_W-1:0]     frame;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      ss_sync_q   <= '1;   // SS idles high: no false fall after reset
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_dly_q    <= 1'b1;
      sclk_dly_q  <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      cmd_q       <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      miso_q      <= 1'b0;
      led_q       <= '0;
      led_valid_q <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ss_sync_q   <= ss_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ss_dly_q    <= ss_dly_d;
      sclk_dly_q  <= sclk_dly_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      cmd_q       <= cmd_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      miso_q      <= miso_d;
      led_q       <= led_d;
      led_valid_q <= led_valid_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
    end
  end

  always_comb begin
    // Frame image, left-aligned into NUM_BYTES bytes: truncated or zero padded.
    img      = {X_pos[7:0], 6'b0, X_pos[9:8], Y_pos[7:0], 6'b0, Y_pos[9:8], 5'b0, Buttons};
    img_wide = {img, {FRAME_W{1'b0}}};
    frame    = img_wide[FRAME_W+IMG_W-1 -: FRAME_W];

    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], SS};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
    ss_s        = ss_sync_q[SYNC_STAGES-1];
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    ss_dly_d    = ss_s;
    sclk_dly_d  = sclk_s;
    ss_fall     = ss_dly_q & ~ss_s;
    ss_rise     = ~ss_dly_q & ss_s;
    sclk_rise   = ~sclk_dly_q & sclk_s;
    sclk_fall   = sclk_dly_q & ~sclk_s;

    state_d     = state_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    cmd_d       = cmd_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    miso_d      = miso_q;
    led_d       = led_q;
    led_valid_d = 1'b0;
    done_d      = 1'b0;
    abort_d     = 1'b0;

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (ss_fall) state_d = LOAD;
      end
      LOAD: begin
        if (ss_rise) begin
          state_d = IDLE;
          abort_d = 1'b1;
          miso_d  = 1'b0;
        end else begin
          tx_d       = frame;
          miso_d     = frame[FRAME_W-1];
          rx_d       = '0;
          cmd_d      = '0;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          state_d = IDLE;
          abort_d = 1'b1;
          miso_d  = 1'b0;
        end else if (sclk_rise) begin
          rx_d      = {rx_q[6:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (byte_cnt_q == '0) cmd_d = {rx_q[6:0], mosi_s};
            byte_cnt_d = byte_cnt_q + 1'b1;
            if (byte_cnt_q == CNT_W'(NUM_BYTES - 1)) begin
              state_d = DONE;
              miso_d  = 1'b0;
            end
          end
        end else if (sclk_fall) begin
          // One long shift register: eight falls walk into the next byte's MSB.
          tx_d   = tx_q << 1;
          miso_d = tx_q[FRAME_W-2];
        end
      end
      DONE: begin
        miso_d = 1'b0;
        if (ss_rise) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (cmd_q[7:2] == LED_CMD) begin
            led_d       = cmd_q[1:0];
            led_valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef JSTK_MISO_TRISTATE_EN
  assign MISO = (state_q == IDLE) ? 1'bz : miso_q;
`else
  assign MISO = miso_q;
`endif
  assign Led         = led_q;
  assign Led_valid   = led_valid_q;
  assign Frame_done  = done_q;
  assign Frame_abort = abort_q;
  assign Busy        = (state_q != IDLE);

endmodule

// File: tb/tb_jstk_spi_responder.sv
module tb_jstk_spi_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] x_pos, y_pos;
  logic [2:0] buttons;
  logic       ss, sclk, mosi;
  logic       miso;
  logic [1:0] led;
  logic       led_valid, frame_done, frame_abort, busy;

  always #5 clk = ~clk;

  jstk_spi_responder #(
    .NUM_BYTES  (5),
    .SYNC_STAGES(2),
    .LED_CMD    (6'b100000)
  ) dut (
    .Clk        (clk),
    .Reset      (rst),
    .X_pos      (x_pos),
    .Y_pos      (y_pos),
    .Buttons    (buttons),
    .SS         (ss),
    .SCLK       (sclk),
    .MOSI       (mosi),
    .MISO       (miso),
    .Led        (led),
    .Led_valid  (led_valid),
    .Frame_done (frame_done),
    .Frame_abort(frame_abort),
    .Busy       (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // Pulse counters, cleared by the stimulus before each frame.
  int cnt_done, cnt_abort, cnt_lv, cnt_both;
  logic [1:0] led_model;

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) cnt_done++;
      if (frame_abort) cnt_abort++;
      if (led_valid) cnt_lv++;
      if (led_valid && frame_done) cnt_both++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_counts();
    cnt_done = 0; cnt_abort = 0; cnt_lv = 0; cnt_both = 0;
  endtask

  // One SS-low window of nbits SCLK pulses at Clk/16. Expected MISO bytes come
  // from the joystick values present before SS falls; perturb changes the
  // inputs mid-frame, which must not affect the frame in flight.
  task automatic run_frame(input int nbits, input logic [7:0] cmd, input bit perturb);
    logic [39:0] img;
    logic [7:0]  mosi_bytes [0:7];
    logic [63:0] cap;
    logic [7:0]  exp_byte;
    bit          full, led_hit;
    img = {x_pos[7:0], 6'b0, x_pos[9:8], y_pos[7:0], 6'b0, y_pos[9:8], 5'b0, buttons};
    mosi_bytes[0] = cmd;
    for (int k = 1; k < 8; k++) mosi_bytes[k] = 8'($urandom);
    cap = '0;
    clear_counts();
    @(negedge clk);
    ss = 1'b0;
    wait_clk(8);
    check_eq("busy_in_frame", {31'b0, busy}, 32'd1);
    for (int i = 0; i < nbits; i++) begin
      mosi = mosi_bytes[i / 8][7 - (i % 8)];
      wait_clk(8);
      sclk = 1'b1;
      cap[63 - i] = miso;
      if (perturb && i == 10) begin
        x_pos   = 10'($urandom);
        y_pos   = 10'($urandom);
        buttons = 3'($urandom);
      end
      wait_clk(8);
      sclk = 1'b0;
    end
    wait_clk(8);
    ss = 1'b1;
    wait_clk(10);

    for (int b = 0; b < nbits / 8; b++) begin
      exp_byte = (b < 5) ? img[39 - 8*b -: 8] : 8'h00;
      check_eq($sformatf("miso_byte%0d", b), {24'b0, cap[63 - 8*b -: 8]}, {24'b0, exp_byte});
    end
    full    = (nbits >= 40);
    led_hit = full && (cmd[7:2] == 6'b100000);
    if (led_hit) led_model = cmd[1:0];
    check_eq("frame_done_cnt", cnt_done, full ? 1 : 0);
    check_eq("frame_abort_cnt", cnt_abort, full ? 0 : 1);
    check_eq("led_valid_cnt", cnt_lv, led_hit ? 1 : 0);
    check_eq("led_valid_with_done", cnt_both, led_hit ? 1 : 0);
    check_eq("led", {30'b0, led}, {30'b0, led_model});
    check_eq("busy_after", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
    x_pos = '0; y_pos = '0; buttons = '0;
    led_model = 2'b00;
    clear_counts();
    wait_clk(3);
    check_eq("rst_miso", {31'b0, miso}, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_led", {30'b0, led}, 32'd0);
    rst = 1'b0;
    wait_clk(3);
    check_eq("post_rst_pulses", {29'b0, led_valid, frame_done, frame_abort}, 32'd0);
    check_eq("post_rst_busy", {31'b0, busy}, 32'd0);

    // Reference frame.
    x_pos = 10'h2A5; y_pos = 10'h13C; buttons = 3'b101;
    run_frame(40, 8'h00, 1'b0);
    // SetLED with mid-frame input changes, then a non-command frame.
    x_pos = 10'h2A5; y_pos = 10'h13C; buttons = 3'b101;
    run_frame(40, 8'b100000_11, 1'b1);
    run_frame(40, 8'h00, 1'b0);
    // Abort after 19 bits with a SetLED opcode: Led must stay.
    run_frame(19, 8'b100000_01, 1'b0);
    run_frame(40, 8'b100000_10, 1'b0);
    // Overlong window: bytes past the frame read as zero.
    run_frame(48, 8'h5A, 1'b0);

    for (int r = 0; r < 22; r++) begin
      x_pos   = 10'($urandom);
      y_pos   = 10'($urandom);
      buttons = 3'($urandom);
      run_frame(($urandom_range(0, 1) == 1) ? 40 : int'($urandom_range(1, 48)),
                ($urandom_range(0, 1) == 1) ? {6'b100000, 2'($urandom)} : 8'($urandom),
                1'b1);
    end

    // Reset asserted in the middle of a frame.
    clear_counts();
    @(negedge clk);
    ss = 1'b0;
    wait_clk(8);
    for (int i = 0; i < 12; i++) begin
      mosi = 1'($urandom);
      wait_clk(8); sclk = 1'b1;
      wait_clk(8); sclk = 1'b0;
    end
    wait_clk(4);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("midrst_miso", {31'b0, miso}, 32'd0);
    check_eq("midrst_busy", {31'b0, busy}, 32'd0);
    check_eq("midrst_led", {30'b0, led}, 32'd0);
    check_eq("midrst_pulses", {29'b0, led_valid, frame_done, frame_abort}, 32'd0);
    led_model = 2'b00;
    @(negedge clk);
    ss = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(12);
    check_eq("midrst_no_pulses", cnt_done + cnt_abort + cnt_lv, 0);
    x_pos = 10'h3FF; y_pos = 10'h001; buttons = 3'b010;
    run_frame(40, 8'b100000_01, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
